// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative shift-add multiplier and restoring divider
// Define MULT_DIV_UNIT_DIV_EN to build the divider; without it div/divu complete at once with op_error.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             op_error
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] mcand;
  logic             neg_res;

  logic             signed_in;
  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic             last;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]   mul_work;
  logic [2*WIDTH-1:0] product;

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign last = (cnt == CW'(WIDTH - 1));

  assign signed_in = ~op[0];
  assign a_neg_in  = signed_in & inA[WIDTH-1];
  assign b_neg_in  = signed_in & inB[WIDTH-1];
  assign a_mag_in  = a_neg_in ? -inA : inA;
  assign b_mag_in  = b_neg_in ? -inB : inB;

  // Multiply keeps the product as {acc, work}, shifting right as multiplier bits retire.
  always_comb begin
    mul_sum  = {1'b0, acc} + (work[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    mul_acc  = mul_sum[WIDTH:1];
    mul_work = {mul_sum[0], work[WIDTH-1:1]};
    product  = {mul_acc, mul_work};
    if (neg_res)
      product = -product;
  end

`ifdef MULT_DIV_UNIT_DIV_EN
  logic [WIDTH-1:0] a_raw;
  logic             neg_rem;
  logic             b_zero;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_work;

  // Divide keeps the partial remainder in acc and shifts quotient bits into work.
  always_comb begin
    rem_sh   = {acc, work[WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, mcand});
    div_diff = rem_sh[WIDTH-1:0] - mcand;
    div_acc  = div_ge ? div_diff : rem_sh[WIDTH-1:0];
    div_work = {work[WIDTH-2:0], div_ge};
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= 2'b00;
      cnt         <= '0;
      acc         <= '0;
      work        <= '0;
      mcand       <= '0;
      neg_res     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      op_error    <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
      a_raw       <= '0;
      neg_rem     <= 1'b0;
      b_zero      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            op_q    <= op;
            cnt     <= '0;
            acc     <= '0;
            work    <= a_mag_in;
            mcand   <= b_mag_in;
            neg_res <= a_neg_in ^ b_neg_in;
`ifdef MULT_DIV_UNIT_DIV_EN
            a_raw   <= inA;
            neg_rem <= a_neg_in;
            b_zero  <= (inB == '0);
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!op_q[1]) begin
            acc  <= mul_acc;
            work <= mul_work;
            if (last) begin
              {hi, lo}    <= product;
              div_by_zero <= 1'b0;
              op_error    <= 1'b0;
              state       <= DONE;
            end
          end else begin
`ifdef MULT_DIV_UNIT_DIV_EN
            acc  <= div_acc;
            work <= div_work;
            if (last) begin
              // Divide by zero reports the raw dividend, not the sign-corrected remainder.
              if (b_zero) begin
                hi          <= a_raw;
                lo          <= '1;
                div_by_zero <= 1'b1;
              end else begin
                hi          <= neg_rem ? -div_acc : div_acc;
                lo          <= neg_res ? -div_work : div_work;
                div_by_zero <= 1'b0;
              end
              op_error <= 1'b0;
              state    <= DONE;
            end
`else
            div_by_zero <= 1'b0;
            op_error    <= 1'b1;
            state       <= DONE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
// Divide vectors are selected by MULT_DIV_UNIT_DIV_EN, matching the DUT build.
module tb_mult_div_unit;

  localparam int W = 32;
`ifdef MULT_DIV_UNIT_DIV_EN
  localparam logic [1:0] RST_OP = 2'b11;
`else
  localparam logic [1:0] RST_OP = 2'b01;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;
  logic         op_error;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .inA(inA), .inB(inB), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero), .op_error(op_error)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present operands for one edge, then scramble them to show they were captured.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    inA   = a;
    inB   = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    inA   = ~a;
    inB   = ~b;
    op    = ~o;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic edbz);
    int n;
    launch(o, a, b);
    wait_done(n);
    check({tag, "_lat"}, n, W);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_dbz"}, div_by_zero, edbz);
    check({tag, "_operr"}, op_error, 1'b0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    int cnt;
    int first;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    inA   = '0;
    inB   = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_operr", op_error, 1'b0);
    reset = 1'b0;

    launch(2'b00, 32'd7, 32'hFFFFFFFD);
    check("mult_busy", busy, 1'b1);
    wait_done(n);
    check("mult_lat", n, W);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    check("mult_dbz", div_by_zero, 1'b0);
    check("mult_operr", op_error, 1'b0);
    @(posedge clock);
    #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("hold_lo", lo, 32'hFFFFFFEB);

    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
`ifdef MULT_DIV_UNIT_DIV_EN
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    check("b2b_div_lat", n, W);
    check("b2b_div_lo", lo, 32'hFFFFFFFD);
    check("b2b_div_hi", hi, 32'hFFFFFFFF);
`else
    launch(2'b11, 32'd9, 32'd3);
    wait_done(n);
    check("nodiv_lat", n, 1);
    check("nodiv_operr", op_error, 1'b1);
    check("nodiv_dbz", div_by_zero, 1'b0);
    check("nodiv_hi", hi, 32'hFFFFFFFE);
    check("nodiv_lo", lo, 32'h00000001);
`endif
    @(posedge clock);
    #1;

`ifdef MULT_DIV_UNIT_DIV_EN
    run_vec("divu_zero", 2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1);
    run_vec("div_zero_neg", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_vec("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_vec("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_vec("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    run_vec("divu_big", 2'b11, 32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF, 1'b0);
`endif
    run_vec("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
    run_vec("mult_m1m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
    run_vec("multu_mix", 2'b01, 32'h80000000, 32'd3, 32'h1, 32'h80000000, 1'b0);

    launch(2'b01, 32'd3, 32'd4);
    cnt   = 0;
    first = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 4) begin
        start = 1'b1;
        inA   = 32'd5;
        inB   = 32'd6;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    start = 1'b0;
    check("ignore_start_pulses", cnt, 1);
    check("ignore_start_lat", first, W);
    check("ignore_start_lo", lo, 32'd12);
    check("ignore_start_hi", hi, 32'd0);

    launch(RST_OP, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done) cnt++;
    end
    check("midrst_no_done", cnt, 0);

    reset = 1'b1;
    start = 1'b1;
    op    = 2'b01;
    inA   = 32'd2;
    inB   = 32'd2;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_over_start", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 4 to 64.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The module SHALL have port op, input, 2 bits: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 The module SHALL have ports inA and inB, input, WIDTH bits each: multiplicand/multiplier, or dividend/divisor.
REQ-007 The module SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 The module SHALL have ports hi and lo, output, WIDTH bits each: product upper/lower half, or remainder/quotient.
REQ-010 The module SHALL have port div_by_zero, output, 1 bit: the completed divide had inB == 0.
REQ-011 The module SHALL have port op_error, output, 1 bit: the completed op was not supported in this build.

Function
REQ-012 The state machine SHALL have states IDLE, RUN and DONE; busy = (state == RUN); done = (state == DONE).
REQ-013 start SHALL be accepted only at an edge where busy = 0, i.e. in IDLE or DONE; at acceptance op, inA and inB are captured, and the state goes to RUN with the iteration counter at 0.
REQ-014 start SHALL be ignored while busy = 1; captured operands and op are unaffected by later input changes.
REQ-015 RUN SHALL perform exactly one shift-add (multiply) or restoring-subtract (divide) iteration per edge, on operand magnitudes, for WIDTH edges.
REQ-016 If start is accepted at edge k, hi and lo SHALL update and the state SHALL enter DONE at edge k+WIDTH; done is high for the cycle after that edge; latency is WIDTH+1 edges from accepting start to done falling.
REQ-017 From DONE, the state SHALL go to IDLE at the next edge unless start is present, in which case it SHALL go to RUN (back-to-back operation, no idle gap).
REQ-018 hi, lo, div_by_zero and op_error SHALL hold their values until the next completion or reset.
REQ-019 For mult/multu, {hi,lo} SHALL be the full 2*WIDTH-bit product; for mult, sign correction is applied at the final edge.
REQ-020 For div/divu, lo SHALL be the quotient truncated toward zero, and hi SHALL be the remainder carrying the dividend's sign.
REQ-021 For signed div with inA = -2^(WIDTH-1) and inB = -1, the result SHALL be lo = -2^(WIDTH-1) and hi = 0, with no flag.
REQ-022 A divide with inB = 0 SHALL still take the full latency and complete with lo = all ones, hi = inA and div_by_zero = 1.
REQ-023 div_by_zero and op_error SHALL be 0 on every completion where their condition is false.

Reset
REQ-024 At any edge with reset = 1, including during RUN, the unit SHALL go to IDLE with busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0 and op_error = 0; any in-progress operation is discarded with no done pulse.
REQ-025 reset SHALL take priority over start on the same edge.

Configuration
REQ-026 Macro MULT_DIV_UNIT_DIV_EN defined: the divider datapath is built and ops 10/11 behave as REQ-020 to REQ-022.
REQ-027 Macro undefined: there is no divider logic; a div/divu accepted at edge k SHALL enter DONE at edge k+1 with op_error = 1, hi and lo unchanged, and div_by_zero = 0. Multiply behaviour is identical in both builds.

Verification (WIDTH = 32, DIV_EN defined unless noted)
REQ-028 mult with 7 and 0xFFFFFFFD -> done 33 edges after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-029 multu with 0xFFFFFFFF and 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; then div with 0xFFFFFFF9 and 2 issued in the DONE cycle -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-030 divu with 100 and 0 -> done after 33 edges; div_by_zero = 1, lo = 0xFFFFFFFF, hi = 0x00000064.
REQ-031 start pulsed again at cycle 5 of a multu with 3 and 4 using new operands -> exactly one done pulse; lo = 12, hi = 0.
REQ-032 reset asserted at cycle 10 of a div -> next cycle busy = 0, hi = lo = 0; no done pulse follows.
REQ-033 MULT_DIV_UNIT_DIV_EN undefined, divu with 9 and 3 -> done one edge later; op_error = 1; hi and lo keep their prior values.
